// File: rtl/vdp_super_pkg.sv
// Shared types for the super-res VRAM write path.
// Word/address types, CPU port selectors and packing constants.
package vdp_super_pkg;

  typedef logic [16:0] super_vram_addr_t;
  typedef logic [31:0] super_word_t;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_ADDR_L,
    SEL_ADDR_M,
    SEL_ADDR_H
  } cpu_sel_t;

  typedef struct packed {
    super_vram_addr_t addr;
    super_word_t      data;
  } super_wr_t;

  localparam int WORD_ADDR_STEP = 2;
  localparam int COLOR_BYTES    = 3;
  localparam int MID_BYTES      = 4;

endpackage

// File: rtl/vdp_super_write_fifo.sv
// Sync FIFO of {addr,data} word writes with a registered head entry.
// Head/valid are computed from next-state so a push shows one cycle later.
module vdp_super_write_fifo
  import vdp_super_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  super_wr_t     i_entry,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_head_vld,
  output super_wr_t     o_head
);

  localparam int PW = $clog2(DEPTH);

  super_wr_t     r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_head_vld;
  super_wr_t     r_head;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_n;
  logic [PW-1:0] w_rptr_n;
  logic          w_bypass;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = i_pop & r_head_vld;
  assign w_push    = i_push & (~w_full | w_pop);
  assign w_count_n = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rptr_n  = r_rptr + PW'(w_pop);
  // New entry lands straight in the head when nothing older remains
  assign w_bypass  = w_push & ((r_count - CW'(w_pop)) == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_head_vld <= 1'b0;
      r_head     <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_entry;
        r_wptr        <= r_wptr + PW'(1);
      end
      r_rptr     <= w_rptr_n;
      r_count    <= w_count_n;
      r_head_vld <= (w_count_n != '0);
      if (w_count_n != '0)
        r_head <= w_bypass ? i_entry : r_mem[w_rptr_n];
    end
  end

  assign o_full     = w_full;
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_vld = r_head_vld;
  assign o_head     = r_head;

endmodule

// File: rtl/vdp_super_vram_writer.sv
// CPU byte packer for the super-res framebuffer (24bpp / 16bpp words).
// Packs bytes into 32-bit words, queues them and issues req/ack writes.
module vdp_super_vram_writer
  import vdp_super_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        super_color,
  input  logic        super_mid,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_sel,
  input  logic [7:0]  cpu_data,
  output logic        busy,
  output logic        overrun,
  output logic        mem_wr_req,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic        mem_wr_ack
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  super_vram_addr_t r_addr;
  logic [1:0]       r_phase;
  super_word_t      r_word;
  logic             r_push;
  super_wr_t        r_push_ent;
  logic             r_overrun;
  logic             r_enable_d;
  logic [1:0]       r_mode_d;

  cpu_sel_t    w_sel;
  logic [1:0]  w_mode;
  logic        w_data_wr;
  logic        w_addr_wr;
  logic        w_clear;
  logic [1:0]  w_last;
  logic        w_done;
  super_word_t w_word;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic        w_head_vld;
  super_wr_t   w_head;
  logic        w_pop;

  assign w_sel     = cpu_sel_t'(cpu_sel);
  assign w_mode    = {super_color, ~super_color & super_mid};
  assign w_data_wr = cpu_wr & (w_sel == SEL_DATA) & enable
                   & (w_mode != 2'b00);
  assign w_addr_wr = cpu_wr & (w_sel != SEL_DATA);
  // Address write, falling enable or a mode change restart the word
  assign w_clear   = w_addr_wr
                   | (r_enable_d & ~enable)
                   | (enable & r_enable_d & (w_mode != r_mode_d));
  assign w_last    = super_color ? 2'(COLOR_BYTES - 1)
                                 : 2'(MID_BYTES - 1);
  assign w_done    = w_data_wr & ~w_clear & (r_phase == w_last);
  assign w_pop     = mem_wr_ack & w_head_vld;

  always_comb begin
    w_word = r_word;
    if (super_color) begin
      w_word[31:24] = 8'h00;
      case (r_phase)
        2'd0:    w_word[23:16] = cpu_data;
        2'd1:    w_word[15:8]  = cpu_data;
        default: w_word[7:0]   = cpu_data;
      endcase
    end else begin
      case (r_phase)
        2'd0:    w_word[31:24] = cpu_data;
        2'd1:    w_word[23:16] = cpu_data;
        2'd2:    w_word[15:8]  = cpu_data;
        default: w_word[7:0]   = cpu_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_phase    <= '0;
      r_word     <= '0;
      r_push     <= 1'b0;
      r_push_ent <= '0;
      r_overrun  <= 1'b0;
      r_enable_d <= 1'b0;
      r_mode_d   <= '0;
    end else begin
      r_enable_d <= enable;
      r_mode_d   <= w_mode;
      r_push     <= w_done;
      if (w_done)
        r_push_ent <= '{addr: r_addr, data: w_word};
      if (w_addr_wr) begin
        unique case (w_sel)
          SEL_ADDR_L: r_addr[7:0]  <= cpu_data;
          SEL_ADDR_M: r_addr[15:8] <= cpu_data;
          SEL_ADDR_H: r_addr[16]   <= cpu_data[0];
          default:    r_addr       <= r_addr;
        endcase
      end else if (w_done) begin
        r_addr <= r_addr + 17'(WORD_ADDR_STEP);
      end
      if (w_clear || w_done) begin
        r_phase <= '0;
        r_word  <= '0;
      end else if (w_data_wr) begin
        r_phase <= r_phase + 2'd1;
        r_word  <= w_word;
      end
      if (r_push && w_full && !w_pop)
        r_overrun <= 1'b1;
      else if (w_addr_wr)
        r_overrun <= 1'b0;
    end
  end

  vdp_super_write_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (r_push),
    .i_entry    (r_push_ent),
    .i_pop      (mem_wr_ack),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_head_vld (w_head_vld),
    .o_head     (w_head)
  );

  logic w_unused;
  assign w_unused = w_empty ^ (^w_count);

  assign busy       = w_full;
  assign overrun    = r_overrun;
  assign mem_wr_req = w_head_vld;
  assign mem_addr   = w_head.addr;
  assign mem_data   = w_head.data;

endmodule
